// File: rtl/mxint8_block_assembler.sv
// Assembles a streamed MXINT8 block (shared E8M0 scale plus BLOCK_SIZE int8 elements, LANES per beat)
// into one parallel block buffer, with valid/ready handshakes on the input and output sides.
module mxint8_block_assembler #(
    parameter int BLOCK_SIZE    = 32,
    parameter int ELEMENT_WIDTH = 8,
    parameter int SCALE_WIDTH   = 8,
    parameter int LANES         = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [LANES-1:0][ELEMENT_WIDTH-1:0]       i_lane_elements,
    input  logic [SCALE_WIDTH-1:0]                    i_scale,
    input  logic                                      i_last,
    output logic                                      o_valid,
    input  logic                                      i_ready,
    output logic [BLOCK_SIZE-1:0][ELEMENT_WIDTH-1:0]  o_mxint8_elements,
    output logic [SCALE_WIDTH-1:0]                    o_scale,
    output logic                                      o_scale_nan,
    output logic                                      o_has_unused,
    output logic                                      o_err_len
);

    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    // The one int8 bit pattern with no signed-magnitude meaning: sign bit set, all other bits clear.
    localparam logic [ELEMENT_WIDTH-1:0] UNUSED_CODE = {1'b1, {(ELEMENT_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic lanes_have_unused(input logic [LANES-1:0][ELEMENT_WIDTH-1:0] lanes);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            hit = hit | (lanes[j] == UNUSED_CODE);
        end
        return hit;
    endfunction

    function automatic logic scale_is_nan(input logic [SCALE_WIDTH-1:0] scale);
        return &scale;
    endfunction

    state_t                                        state_r;
    logic [CW-1:0]                                 beat_cnt_r;
    logic                                          ready_r;
    logic                                          valid_r;
    logic                                          err_len_r;
    logic [SCALE_WIDTH-1:0]                        scale_r;
    logic                                          scale_nan_r;
    logic                                          has_unused_r;
    logic [BEATS-1:0][LANES-1:0][ELEMENT_WIDTH-1:0] blk_r;

    logic accept_s;
    logic first_beat_s;
    logic last_slot_s;
    logic beat_unused_s;
    logic unused_acc_s;

    assign accept_s      = i_valid & ready_r;
    assign first_beat_s  = (beat_cnt_r == {CW{1'b0}});
    assign last_slot_s   = (beat_cnt_r == LAST_BEAT);
    assign beat_unused_s = lanes_have_unused(i_lane_elements);
    // Beat 0 restarts the sticky flag so nothing leaks in from a previous block.
    assign unused_acc_s  = beat_unused_s | (~first_beat_s & has_unused_r);

    // Block FSM: beat capture, length checking and the output handoff.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= FILL;
            beat_cnt_r   <= {CW{1'b0}};
            ready_r      <= 1'b1;
            valid_r      <= 1'b0;
            err_len_r    <= 1'b0;
            scale_r      <= {SCALE_WIDTH{1'b0}};
            scale_nan_r  <= 1'b0;
            has_unused_r <= 1'b0;
            blk_r        <= '0;
        end else begin
            err_len_r <= 1'b0;
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        blk_r[beat_cnt_r] <= i_lane_elements;
                        if (first_beat_s) begin
                            scale_r     <= i_scale;
                            scale_nan_r <= scale_is_nan(i_scale);
                        end
                        if (i_last && last_slot_s) begin
                            state_r      <= HOLD;
                            ready_r      <= 1'b0;
                            valid_r      <= 1'b1;
                            beat_cnt_r   <= {CW{1'b0}};
                            has_unused_r <= unused_acc_s;
                        end else if (i_last || last_slot_s) begin
                            // Short or long block: drop it; stale slots get overwritten by the next one.
                            err_len_r    <= 1'b1;
                            beat_cnt_r   <= {CW{1'b0}};
                            has_unused_r <= 1'b0;
                        end else begin
                            beat_cnt_r   <= beat_cnt_r + CW'(1);
                            has_unused_r <= unused_acc_s;
                        end
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        state_r <= FILL;
                        ready_r <= 1'b1;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= FILL;
                    ready_r    <= 1'b1;
                    valid_r    <= 1'b0;
                    beat_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign o_ready           = ready_r;
    assign o_valid           = valid_r;
    assign o_err_len         = err_len_r;
    assign o_scale           = scale_r;
    assign o_scale_nan       = scale_nan_r;
    assign o_has_unused      = has_unused_r;
    assign o_mxint8_elements = blk_r;

endmodule

// File: tb/tb_mxint8_block_assembler.sv
// Directed self-checking bench for mxint8_block_assembler (BLOCK_SIZE=32, LANES=4, 8 beats per block).
module tb_mxint8_block_assembler;

    logic               i_clk;
    logic               i_rst;
    logic               i_valid;
    logic               o_ready;
    logic [3:0][7:0]    i_lane_elements;
    logic [7:0]         i_scale;
    logic               i_last;
    logic               o_valid;
    logic               i_ready;
    logic [31:0][7:0]   o_mxint8_elements;
    logic [7:0]         o_scale;
    logic               o_scale_nan;
    logic               o_has_unused;
    logic               o_err_len;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_elem [32];

    mxint8_block_assembler #(
        .BLOCK_SIZE(32), .ELEMENT_WIDTH(8), .SCALE_WIDTH(8), .LANES(4)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_lane_elements(i_lane_elements), .i_scale(i_scale), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_mxint8_elements(o_mxint8_elements),
        .o_scale(o_scale), .o_scale_nan(o_scale_nan), .o_has_unused(o_has_unused),
        .o_err_len(o_err_len)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_seq(input int base);
        for (int k = 0; k < 32; k++) exp_elem[k] = 8'((base + k) & 255);
    endtask

    function automatic logic [255:0] pack_exp();
        logic [255:0] p;
        for (int k = 0; k < 32; k++) p[k*8 +: 8] = exp_elem[k];
        return p;
    endfunction

    // Drives nbeats beats from exp_elem; i_last on beat last_at (-1 for none). Returns #1 after final edge.
    task automatic send_block(input int nbeats, input int last_at, input logic [7:0] scale);
        for (int b = 0; b < nbeats; b++) begin
            i_valid = 1'b1;
            i_scale = scale;
            i_last  = (b == last_at);
            for (int j = 0; j < 4; j++) i_lane_elements[j] = exp_elem[b*4 + j];
            @(posedge i_clk); #1;
            if (b != nbeats - 1) check("no_early_valid", {255'd0, o_valid}, 256'd0);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic handoff();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        check("handoff_valid", {255'd0, o_valid}, 256'd0);
        check("handoff_ready", {255'd0, o_ready}, 256'd1);
    endtask

    initial begin
        int seen;
        int g;
        logic acc;
        logic [255:0] held;

        i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
        i_scale = 8'h00; i_lane_elements = '0;
        #12;
        check("rst_ready", {255'd0, o_ready}, 256'd1);
        check("rst_valid", {255'd0, o_valid}, 256'd0);
        check("rst_err", {255'd0, o_err_len}, 256'd0);
        check("rst_scale", {248'd0, o_scale}, 256'd0);
        check("rst_elems", o_mxint8_elements, 256'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // 1: plain block k -> k, scale 7F
        set_seq(0);
        send_block(8, 7, 8'h7F);
        check("t1_valid", {255'd0, o_valid}, 256'd1);
        check("t1_ready", {255'd0, o_ready}, 256'd0);
        check("t1_elems", o_mxint8_elements, pack_exp());
        check("t1_scale", {248'd0, o_scale}, {248'd0, 8'h7F});
        check("t1_nan", {255'd0, o_scale_nan}, 256'd0);
        check("t1_unused", {255'd0, o_has_unused}, 256'd0);
        handoff();

        // 2: unused code in slot 13, NaN scale, downstream stalls 5 cycles
        set_seq(0);
        exp_elem[13] = 8'h80;
        i_ready = 1'b0;
        send_block(8, 7, 8'hFF);
        held = pack_exp();
        check("t2_unused", {255'd0, o_has_unused}, 256'd1);
        check("t2_nan", {255'd0, o_scale_nan}, 256'd1);
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_lane_elements = {8'h55, 8'h55, 8'h55, 8'h55};
            i_scale = 8'h01;
            i_last  = 1'b1;
            @(posedge i_clk); #1;
            check("t2_hold_valid", {255'd0, o_valid}, 256'd1);
            check("t2_hold_ready", {255'd0, o_ready}, 256'd0);
            check("t2_hold_elems", o_mxint8_elements, held);
            check("t2_hold_scale", {248'd0, o_scale}, {248'd0, 8'hFF});
        end
        i_valid = 1'b0; i_last = 1'b0;
        handoff();

        // 3: short block (last on beat 3) with an unused code, then a clean block
        set_seq(8'h40);
        exp_elem[5] = 8'h80;
        send_block(4, 3, 8'h33);
        check("t3_err", {255'd0, o_err_len}, 256'd1);
        check("t3_no_valid", {255'd0, o_valid}, 256'd0);
        check("t3_unused_clr", {255'd0, o_has_unused}, 256'd0);
        @(posedge i_clk); #1;
        check("t3_err_pulse", {255'd0, o_err_len}, 256'd0);
        set_seq(8'h20);
        send_block(8, 7, 8'h10);
        check("t3_valid", {255'd0, o_valid}, 256'd1);
        check("t3_elems", o_mxint8_elements, pack_exp());
        check("t3_unused", {255'd0, o_has_unused}, 256'd0);
        check("t3_scale", {248'd0, o_scale}, {248'd0, 8'h10});
        handoff();

        // 4: long block (no last on beat 7), then a clean block with new scale
        set_seq(8'h01);
        send_block(8, -1, 8'hAA);
        check("t4_err", {255'd0, o_err_len}, 256'd1);
        check("t4_no_valid", {255'd0, o_valid}, 256'd0);
        set_seq(8'h30);
        send_block(8, 7, 8'h22);
        check("t4_valid", {255'd0, o_valid}, 256'd1);
        check("t4_err_gone", {255'd0, o_err_len}, 256'd0);
        check("t4_scale", {248'd0, o_scale}, {248'd0, 8'h22});
        check("t4_elems", o_mxint8_elements, pack_exp());
        handoff();

        // 5: back-to-back stream, one block per 9 cycles
        seen = 0; g = 0; i_ready = 1'b1;
        for (int c = 0; c < 27; c++) begin
            i_valid = 1'b1;
            i_scale = 8'h01;
            i_last  = ((g % 8) == 7);
            for (int j = 0; j < 4; j++)
                i_lane_elements[j] = 8'(((g / 8) * 32 + 16 + (g % 8) * 4 + j) & 255);
            acc = o_ready;
            @(posedge i_clk); #1;
            if (acc) g++;
            if (o_valid) begin
                set_seq(seen * 32 + 16);
                check("t5_cycle", 256'(c), 256'(7 + 9 * seen));
                check("t5_elems", o_mxint8_elements, pack_exp());
                seen++;
            end
        end
        i_valid = 1'b0; i_last = 1'b0;
        check("t5_blocks", 256'(seen), 256'd3);

        // 6: async reset after beat 4, then again while holding
        @(posedge i_clk); #1;
        set_seq(8'h50);
        send_block(5, -1, 8'h44);
        i_rst = 1'b1; #1;
        check("t6a_ready", {255'd0, o_ready}, 256'd1);
        check("t6a_valid", {255'd0, o_valid}, 256'd0);
        check("t6a_elems", o_mxint8_elements, 256'd0);
        check("t6a_scale", {248'd0, o_scale}, 256'd0);
        #1 i_rst = 1'b0;
        set_seq(8'h60);
        send_block(8, 7, 8'h12);
        check("t6b_valid", {255'd0, o_valid}, 256'd1);
        check("t6b_elems", o_mxint8_elements, pack_exp());
        i_ready = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1; #1;
        check("t6c_ready", {255'd0, o_ready}, 256'd1);
        check("t6c_valid", {255'd0, o_valid}, 256'd0);
        check("t6c_elems", o_mxint8_elements, 256'd0);
        check("t6c_nan", {255'd0, o_scale_nan}, 256'd0);
        #1 i_rst = 1'b0;
        i_ready = 1'b1;
        set_seq(8'h08);
        send_block(8, 7, 8'h7E);
        check("t6d_valid", {255'd0, o_valid}, 256'd1);
        check("t6d_elems", o_mxint8_elements, pack_exp());
        check("t6d_scale", {248'd0, o_scale}, {248'd0, 8'h7E});
        handoff();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
